// File: rtl/logic_sweep_checker.sv
// Exhaustive truth-table sweeper: steps stim through every N_IN-bit value, waits SETTLE cycles per
// vector, then compares dut_y against exp_y and records the mismatch count and the first failure.
module logic_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 7,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic [N_OUT-1:0]  dut_y,
    input  logic [N_OUT-1:0]  exp_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic [N_OUT-1:0]  first_fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] STIM_ONE    = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       settle_cnt;
    logic [N_OUT-1:0] diff;
    logic             last_vec;

    assign diff     = dut_y ^ exp_y;
    assign last_vec = &stim;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_SETTLE;
            S_SETTLE:       if (settle_cnt == 8'd0) state_next = S_CHECK;
            S_CHECK:        state_next = last_vec ? S_DONE : S_SETTLE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stim            <= '0;
            settle_cnt      <= '0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        stim            <= '0;
                        settle_cnt      <= SETTLE_LOAD;
                        err_count       <= '0;
                        first_fail_vec  <= '0;
                        first_fail_mask <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
                end
                S_CHECK: begin
                    if (diff != '0) begin
                        err_count <= err_count + ERR_ONE;
                        // Only the first failing vector of a sweep is latched.
                        if (err_count == '0) begin
                            first_fail_vec  <= stim;
                            first_fail_mask <= diff;
                        end
                    end
                    // Sweep ends at all-ones; stim holds there instead of wrapping to 0.
                    if (!last_vec) begin
                        stim       <= stim + STIM_ONE;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

endmodule
